// File: rtl/mic_csr_pkg.sv
// Shared register map, IRQ_STATUS field offsets and read FSM states for the microphone CSR block.
package mic_csr_pkg;

    localparam int MAX_CHANNELS = 8;

    localparam logic [3:0] ADDR_IRQ_STATUS  = 4'd0;
    localparam logic [3:0] ADDR_CTRL        = 4'd1;
    localparam logic [3:0] ADDR_IRQ_MASK    = 4'd2;
    localparam logic [3:0] ADDR_FIFO_STATUS = 4'd3;
    localparam logic [3:0] ADDR_DATA_BASE   = 4'd4;

    localparam int IRQ_READY_OFS = 0;
    localparam int IRQ_OVF_OFS   = 8;
    localparam int IRQ_UDF_OFS   = 16;

    typedef enum logic [1:0] {
        IDLE,
        REG,
        POP,
        DATA
    } rd_state_e;

endpackage

// File: rtl/mic_irq_cell.sv
// One sticky IRQ_STATUS bit: a set event beats a same-cycle write-1-to-clear or flush.
// Next state is exported so the interrupt output can be registered without an extra cycle.
module mic_irq_cell (
    input  logic clk_i,
    input  logic rst_i,
    input  logic set_i,
    input  logic clr_i,
    input  logic flush_i,
    output logic q_o,
    output logic d_o
);

    logic bit_q;
    logic bit_d;

    always_comb begin
        bit_d = bit_q;
        if (set_i) begin
            bit_d = 1'b1;
        end else if (clr_i || flush_i) begin
            bit_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign q_o = bit_q;
    assign d_o = bit_d;

endmodule

// File: rtl/mic_csr_multich.sv
// Avalon-MM CSR front end for per-channel microphone FIFOs with sticky interrupt status.
// Register reads take 2 cycles, FIFO data reads 3 (waitrequest held meanwhile); writes are zero-wait in IDLE.
module mic_csr_multich
    import mic_csr_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 24,
    parameter int SIGN_EXT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         avs_s0_write,
    input  logic                         avs_s0_read,
    input  logic [3:0]                   avs_s0_address,
    input  logic [31:0]                  avs_s0_writedata,
    output logic [31:0]                  avs_s0_readdata,
    output logic                         avs_s0_waitrequest,
    output logic                         avm_s0_irq,
    output logic [CHANNELS-1:0]          ch_enable,
    output logic [CHANNELS-1:0]          ch_rd,
    input  logic [CHANNELS*SAMPLE_W-1:0] ch_data,
    input  logic [CHANNELS-1:0]          ch_full,
    input  logic [CHANNELS-1:0]          ch_empty,
    input  logic [CHANNELS-1:0]          ch_irq,
    input  logic [CHANNELS-1:0]          ch_ovf
);

    rd_state_e             state_q, state_d;
    logic [3:0]            addr_q, addr_d;
    logic [CHANNELS-1:0]   sel_q, sel_d;
    logic [31:0]           data_q, data_d;
    logic [CHANNELS-1:0]   ctrl_q, ctrl_d;
    logic [CHANNELS-1:0]   full_q;
    logic [23:0]           mask_q, mask_d;
    logic                  irq_q;

    logic                  wr_en, wr_status, wr_ctrl, wr_mask;
    logic [CHANNELS-1:0]   hit, udf_set, rd_strobe, ovf_evt, flush;
    logic                  hit_empty, wait_c;
    logic [MAX_CHANNELS-1:0] ready_q, ready_d, ovf_q, ovf_d, udf_q, udf_d;
    logic [23:0]           status_q, status_d;
    logic [31:0]           fifo_status, reg_rdata, sel_sample;
    logic [SAMPLE_W-1:0]   sample_raw;
    logic signed [SAMPLE_W-1:0] sample_s;
    logic signed [31:0]    sample_sx;
    logic                  unused_wdata;

    assign wr_en     = avs_s0_write && (state_q == IDLE);
    assign wr_status = wr_en && (avs_s0_address == ADDR_IRQ_STATUS);
    assign wr_ctrl   = wr_en && (avs_s0_address == ADDR_CTRL);
    assign wr_mask   = wr_en && (avs_s0_address == ADDR_IRQ_MASK);

    assign ctrl_d  = wr_ctrl ? avs_s0_writedata[CHANNELS-1:0] : ctrl_q;
    assign mask_d  = wr_mask ? avs_s0_writedata[23:0] : mask_q;
    // Disabling a channel discards its pending data-ready; the sticky error bits survive.
    assign flush   = wr_ctrl ? ~avs_s0_writedata[CHANNELS-1:0] : '0;
    assign ovf_evt = ch_ovf | (ch_full & ~full_q & ctrl_q);

    for (genvar c = 0; c < MAX_CHANNELS; c++) begin : g_ch
        if (c < CHANNELS) begin : g_cell
            mic_irq_cell u_ready (
                .clk_i(clk), .rst_i(rst), .set_i(ch_irq[c]),
                .clr_i(wr_status && avs_s0_writedata[IRQ_READY_OFS+c]),
                .flush_i(flush[c]), .q_o(ready_q[c]), .d_o(ready_d[c])
            );
            mic_irq_cell u_ovf (
                .clk_i(clk), .rst_i(rst), .set_i(ovf_evt[c]),
                .clr_i(wr_status && avs_s0_writedata[IRQ_OVF_OFS+c]),
                .flush_i(1'b0), .q_o(ovf_q[c]), .d_o(ovf_d[c])
            );
            mic_irq_cell u_udf (
                .clk_i(clk), .rst_i(rst), .set_i(udf_set[c]),
                .clr_i(wr_status && avs_s0_writedata[IRQ_UDF_OFS+c]),
                .flush_i(1'b0), .q_o(udf_q[c]), .d_o(udf_d[c])
            );
        end else begin : g_pad
            assign ready_q[c] = 1'b0;
            assign ready_d[c] = 1'b0;
            assign ovf_q[c]   = 1'b0;
            assign ovf_d[c]   = 1'b0;
            assign udf_q[c]   = 1'b0;
            assign udf_d[c]   = 1'b0;
        end
    end

    assign status_q = {udf_q, ovf_q, ready_q};
    assign status_d = {udf_d, ovf_d, ready_d};

    always_comb begin
        hit         = '0;
        hit_empty   = 1'b0;
        sample_raw  = '0;
        fifo_status = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (avs_s0_address == ADDR_DATA_BASE + 4'(c)) begin
                hit[c]    = 1'b1;
                hit_empty = ch_empty[c];
            end
            if (sel_q[c]) begin
                sample_raw = ch_data[c*SAMPLE_W +: SAMPLE_W];
            end
            fifo_status[2*c]   = ch_empty[c];
            fifo_status[2*c+1] = ch_full[c];
        end
    end

    assign sample_s   = sample_raw;
    assign sample_sx  = 32'(sample_s);
    assign sel_sample = (SIGN_EXT != 0) ? $unsigned(sample_sx) : 32'(sample_raw);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        data_d    = data_q;
        wait_c    = 1'b0;
        rd_strobe = '0;
        udf_set   = '0;
        case (state_q)
            IDLE: begin
                if (avs_s0_read) begin
                    wait_c = 1'b1;
                    addr_d = avs_s0_address;
                    sel_d  = hit;
                    if ((|hit) && !hit_empty) begin
                        state_d = POP;
                    end else begin
                        // An empty DATA read degrades to a zero register read and flags underflow.
                        state_d = REG;
                        udf_set = hit;
                    end
                end
            end
            REG:  state_d = IDLE;
            POP: begin
                wait_c    = 1'b1;
                rd_strobe = sel_q;
                data_d    = sel_sample;
                state_d   = DATA;
            end
            DATA: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (addr_q)
            ADDR_IRQ_STATUS:  reg_rdata = {8'h00, status_q};
            ADDR_CTRL:        reg_rdata = 32'(ctrl_q);
            ADDR_IRQ_MASK:    reg_rdata = {8'h00, mask_q};
            ADDR_FIFO_STATUS: reg_rdata = fifo_status;
            default:          reg_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            ctrl_q  <= '0;
            mask_q  <= '0;
            full_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            mask_q  <= mask_d;
            full_q  <= ch_full;
            irq_q   <= |(status_d & mask_d);
        end
    end

    // Reset kills an in-flight access immediately, including a pending pop strobe.
    assign avs_s0_waitrequest = wait_c && !rst;
    assign ch_rd              = rst ? '0 : rd_strobe;
    assign avs_s0_readdata    = rst                ? 32'h0     :
                                (state_q == REG)  ? reg_rdata :
                                (state_q == DATA) ? data_q    : 32'h0;
    assign ch_enable          = ctrl_q;
    assign avm_s0_irq         = irq_q;
    assign unused_wdata       = ^avs_s0_writedata;

endmodule

// File: doc/mic_csr_multich.md
MIC_CSR_MULTICH -- requirements
Module: mic_csr_multich

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of microphone channels (legal 1..8).
REQ-002 SHALL have parameter SAMPLE_W, default 24, sample width per channel (legal 8..32).
REQ-003 SHALL have parameter SIGN_EXT, default 1, which selects sign-extension (1) or zero-extension (0) of samples to 32 bits.
REQ-004 SHALL have one clock; reset SHALL be synchronous and active-high; ports: clk input 1 system clock; rst input 1 synchronous active-high reset.
REQ-005 SHALL have the Avalon-MM slave ports: avs_s0_write input 1; avs_s0_read input 1; avs_s0_address input 4 word address; avs_s0_writedata input 32; avs_s0_readdata output 32; avs_s0_waitrequest output 1.
REQ-006 SHALL have avm_s0_irq output 1, the level interrupt to the CPU.
REQ-007 SHALL have ch_enable output CHANNELS, per-channel capture enable.
REQ-008 SHALL have ch_rd output CHANNELS, a one-cycle FIFO pop strobe per channel.
REQ-009 SHALL have ch_data input CHANNELS*SAMPLE_W, FIFO heads, with channel c at bits [c*SAMPLE_W +: SAMPLE_W].
REQ-010 SHALL have ch_full and ch_empty inputs of width CHANNELS carrying FIFO flags, and ch_irq and ch_ovf inputs of width CHANNELS carrying one-cycle data-ready and overflow event pulses.

Function
REQ-011 SHALL implement this word register map: 0 IRQ_STATUS (W1C); 1 CTRL, bits[CH-1:0] = ch_enable (RW); 2 IRQ_MASK, bits[23:0] (RW); 3 FIFO_STATUS (RO), bit 2c = empty[c] and bit 2c+1 = full[c]; 4..4+CH-1 DATA[c] (RO, pops on read); all other addresses read 0 and ignore writes.
REQ-012 SHALL lay out IRQ_STATUS with bits[7:0] = data-ready pending, bits[15:8] = overflow sticky, bits[23:16] = underflow sticky; bits for channels >= CHANNELS SHALL read 0.
REQ-013 SHALL use read FSM states IDLE, REG, POP, DATA.
REQ-014 In IDLE, on a read of a register (addr 0..3 or unmapped), SHALL assert waitrequest and move to REG; REG SHALL drive readdata with waitrequest=0 and return to IDLE, giving a 2-cycle read.
REQ-015 In IDLE, on a read of DATA[c] with ch_empty[c]=0, SHALL assert waitrequest and move to POP; POP SHALL assert waitrequest and ch_rd[c] for exactly one cycle, then move to DATA; DATA SHALL drive the extended ch_data[c] (captured in POP) with waitrequest=0, then return to IDLE, giving a 3-cycle read.
REQ-016 On a DATA[c] read with ch_empty[c]=1, SHALL take the REG path, return 0, not pulse ch_rd, and set underflow[c].
REQ-017 SHALL drive avs_s0_readdata to 0 in every cycle other than the REG/DATA response cycle; waitrequest SHALL be 0 in IDLE with no read.
REQ-018 SHALL accept writes in IDLE with zero wait states.
REQ-019 SHALL apply writes to IRQ_STATUS as write-1-to-clear per bit; a set event in the same cycle as a clear of that bit SHALL win, leaving the bit at 1.
REQ-020 SHALL set ready[c] on ch_irq[c] and ovf[c] on ch_ovf[c]; ovf[c] SHALL also set on ch_full[c] rising while ch_enable[c]=1.
REQ-021 SHALL register avm_s0_irq as |(IRQ_STATUS & IRQ_MASK), asserted 1 cycle after the causing event.
REQ-022 SHALL clear ready[c] when ch_enable[c] is written 0; sticky bits SHALL be retained.
REQ-023 At most one ch_rd bit SHALL be high per cycle, and never outside POP.

Reset
REQ-024 On rst, SHALL set FSM=IDLE and IRQ_STATUS, CTRL, IRQ_MASK, ch_enable, ch_rd, avm_s0_irq, avs_s0_readdata and avs_s0_waitrequest all to 0.
REQ-025 A reset asserted during POP or DATA SHALL abort the access with no further ch_rd pulse; the response is lost.

Structure
REQ-026 Shared package mic_csr_pkg SHALL hold the address constants, IRQ_STATUS field offsets, the FSM state enum and MAX_CHANNELS=8.
REQ-027 Per-channel sticky/W1C/set-wins logic SHALL be one sub-module, mic_irq_cell, instantiated 3*CHANNELS times.

Verification
REQ-028 Bench SHALL cover: CH=2, SAMPLE_W=24; write CTRL=0x3, push 0x800001 to ch1, read addr 5 -> waitrequest 2 cycles, one ch_rd[1] pulse, readdata=0xFF800001 (SIGN_EXT=1), 0x00800001 with SIGN_EXT=0.
REQ-029 Bench SHALL cover: read addr 4 with ch0 empty -> readdata=0, no ch_rd, IRQ_STATUS bit16=1.
REQ-030 Bench SHALL cover: IRQ_MASK=0x1, pulse ch_irq[0] -> avm_s0_irq=1 next cycle; write IRQ_STATUS=0x1 -> irq=0 next cycle; same-cycle ch_irq[0] with W1C -> bit stays 1.
REQ-031 Bench SHALL cover: ch_full[1] rising with enable[1]=1 -> IRQ_STATUS bit9=1; read addr 3 -> bit3=1.
REQ-032 Bench SHALL cover: rst asserted in POP -> next cycle FSM IDLE, waitrequest=0, all registers 0, no further ch_rd.
REQ-033 Bench SHALL cover: read addr 9 -> 0 in 2 cycles; write addr 9 -> no register change.
